// File: rtl/judge_pkg.sv
// judge_pkg: shared types and helpers for the reaction judge.
//   state_e  - round FSM encoding (idle / answer window open / resolved)
//   btn_code - maps a button index to its operation code
//   sat_inc  - saturating increment for the right/wrong tallies
package judge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned TickCntW = 8;

  // Buttons are numbered in reverse: btn[0] carries the highest code.
  function automatic int unsigned btn_code(input int unsigned num_btn, input int unsigned idx);
    return num_btn - 1 - idx;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/btn_edge_pri.sv
// btn_edge_pri: rising-edge detector and lowest-index priority encoder for the answer buttons.
//   clk, rst : clock, asynchronous active-high reset
//   btn      : debounced, clk-synchronous button levels
//   press    : at least one button rose this cycle
//   code     : operation code of the lowest-index rising button (0 when press is low)
module btn_edge_pri
  import judge_pkg::*;
#(
  parameter int unsigned NUM_BTN = 4,
  parameter int unsigned ACT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic               press,
  output logic [ACT_W-1:0]   code
);

  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] new_press;
  logic               found;

  // Sampled every cycle regardless of FSM state, so a button already held when a round
  // opens never looks like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  assign new_press = btn & ~btn_q;
  assign press     = |new_press;

  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (new_press[i] && !found) begin
        code  = ACT_W'(btn_code(NUM_BTN, i));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reaction_judge.sv
// reaction_judge: per-round answer judge for the reflex game.
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : one-cycle timebase strobe
//   round_start  : opens an answer window and latches action
//   action       : expected operation code for the round
//   btn          : debounced button levels
//   score_clr    : synchronous clear of both tallies (wins over increments)
//   busy         : answer window open
//   operation    : code of the last judged press (held)
//   op_valid     : one-cycle pulse when operation updates
//   round_done   : one-cycle pulse when a round resolves
//   round_hit    : last round was a correct press (held until next round_start)
//   right_time   : saturating count of correct rounds
//   wrong_time   : saturating count of wrong presses and timeouts
module reaction_judge
  import judge_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned ACT_W        = 2,
  parameter int unsigned WINDOW_TICKS = 40,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               round_start,
  input  logic [ACT_W-1:0]   action,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               score_clr,
  output logic               busy,
  output logic [ACT_W-1:0]   operation,
  output logic               op_valid,
  output logic               round_done,
  output logic               round_hit,
  output logic [CNT_W-1:0]   right_time,
  output logic [CNT_W-1:0]   wrong_time
);

  localparam logic [CNT_W-1:0]    CntMax   = '1;
  localparam logic [TickCntW-1:0] LastTick = TickCntW'(WINDOW_TICKS - 1);

  state_e                state_q, state_d;
  logic [TickCntW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ACT_W-1:0]      act_q, act_d;
  logic [ACT_W-1:0]      operation_q, operation_d;
  logic                  op_valid_q, op_valid_d;
  logic                  round_hit_q, round_hit_d;
  logic [CNT_W-1:0]      right_q, right_d;
  logic [CNT_W-1:0]      wrong_q, wrong_d;

  logic                  press;
  logic [ACT_W-1:0]      press_code;

  btn_edge_pri #(
    .NUM_BTN(NUM_BTN),
    .ACT_W  (ACT_W)
  ) u_btn_edge_pri (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press),
    .code (press_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      act_q       <= '0;
      operation_q <= '0;
      op_valid_q  <= 1'b0;
      round_hit_q <= 1'b0;
      right_q     <= '0;
      wrong_q     <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      act_q       <= act_d;
      operation_q <= operation_d;
      op_valid_q  <= op_valid_d;
      round_hit_q <= round_hit_d;
      right_q     <= right_d;
      wrong_q     <= wrong_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    act_d       = act_q;
    operation_d = operation_q;
    op_valid_d  = 1'b0;
    round_hit_d = round_hit_q;
    right_d     = right_q;
    wrong_d     = wrong_q;

    unique case (state_q)
      StIdle: begin
        if (round_start) begin
          act_d       = action;
          tick_cnt_d  = '0;
          round_hit_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A press outranks a coincident final tick.
        if (press) begin
          operation_d = press_code;
          op_valid_d  = 1'b1;
          state_d     = StDone;
          if (press_code == act_q) begin
            right_d     = CNT_W'(sat_inc(32'(right_q), 32'(CntMax)));
            round_hit_d = 1'b1;
          end else begin
            wrong_d     = CNT_W'(sat_inc(32'(wrong_q), 32'(CntMax)));
            round_hit_d = 1'b0;
          end
        end else if (tick) begin
          if (tick_cnt_q == LastTick) begin
            wrong_d     = CNT_W'(sat_inc(32'(wrong_q), 32'(CntMax)));
            round_hit_d = 1'b0;
            state_d     = StDone;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (score_clr) begin
      right_d = '0;
      wrong_d = '0;
    end
  end

  assign busy       = (state_q == StWait);
  assign round_done = (state_q == StDone);
  assign operation  = operation_q;
  assign op_valid   = op_valid_q;
  assign round_hit  = round_hit_q;
  assign right_time = right_q;
  assign wrong_time = wrong_q;

endmodule

// File: tb/tb_reaction_judge.sv
// tb_reaction_judge: scoreboard bench for reaction_judge. Stimulus pushes the expected
// round result; a negedge monitor pops and compares whenever round_done is presented.
module tb_reaction_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       round_start;
  logic [1:0] action;
  logic [3:0] btn;
  logic       score_clr;
  logic       busy;
  logic [1:0] operation;
  logic       op_valid;
  logic       round_done;
  logic       round_hit;
  logic [7:0] right_time;
  logic [7:0] wrong_time;

  typedef struct {
    logic       has_op;
    logic [1:0] op;
    logic       hit;
    logic [7:0] right;
    logic [7:0] wrong;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_right = 0;
  int   exp_wrong = 0;
  logic [1:0] exp_op = 2'd0;

  reaction_judge #(
    .NUM_BTN     (4),
    .ACT_W       (2),
    .WINDOW_TICKS(40),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .round_start(round_start),
    .action     (action),
    .btn        (btn),
    .score_clr  (score_clr),
    .busy       (busy),
    .operation  (operation),
    .op_valid   (op_valid),
    .round_done (round_done),
    .round_hit  (round_hit),
    .right_time (right_time),
    .wrong_time (wrong_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [1:0] a);
    action      = a;
    round_start = 1'b1;
    cyc();
    round_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  // Expected result of a judged press; code is the bench's own decode of the button.
  task automatic expect_press(input logic [1:0] code, input logic [1:0] act, input logic clr);
    exp_t e;
    if (code == act) begin
      exp_right = (exp_right >= 255) ? 255 : exp_right + 1;
    end else begin
      exp_wrong = (exp_wrong >= 255) ? 255 : exp_wrong + 1;
    end
    if (clr) begin
      exp_right = 0;
      exp_wrong = 0;
    end
    exp_op   = code;
    e.has_op = 1'b1;
    e.op     = code;
    e.hit    = (code == act);
    e.right  = 8'(exp_right);
    e.wrong  = 8'(exp_wrong);
    exp_q.push_back(e);
  endtask

  task automatic expect_timeout();
    exp_t e;
    exp_wrong = (exp_wrong >= 255) ? 255 : exp_wrong + 1;
    e.has_op  = 1'b0;
    e.op      = exp_op;
    e.hit     = 1'b0;
    e.right   = 8'(exp_right);
    e.wrong   = 8'(exp_wrong);
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] b, input logic clr);
    btn       = b;
    score_clr = clr;
    cyc();
    btn       = '0;
    score_clr = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_operation"}, operation, 0);
    check({tag, "_op_valid"}, op_valid, 0);
    check({tag, "_round_done"}, round_done, 0);
    check({tag, "_round_hit"}, round_hit, 0);
    check({tag, "_right"}, right_time, 0);
    check({tag, "_wrong"}, wrong_time, 0);
  endtask

  // Monitor: compare every presented round result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (op_valid && !round_done) check("op_valid_without_round_done", 1, 0);
      if (round_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_round_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("op_valid", op_valid, e.has_op);
          check("operation", operation, e.op);
          check("round_hit", round_hit, e.hit);
          check("right_time", right_time, e.right);
          check("wrong_time", wrong_time, e.wrong);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; round_start = 1'b0; action = '0; btn = '0; score_clr = 1'b0;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // Correct press after 5 ticks: btn[0] -> code 3.
    start_round(2'd3);
    check("busy_in_wait", busy, 1);
    ticks(5);
    expect_press(2'd3, 2'd3, 1'b0);
    press(4'b0001, 1'b0);
    check("idle_after_hit", busy, 0);

    // Wrong press: btn[1] -> code 2 against action 0.
    start_round(2'd0);
    expect_press(2'd2, 2'd0, 1'b0);
    press(4'b0010, 1'b0);

    // Timeout after exactly 40 ticks.
    start_round(2'd1);
    ticks(39);
    check("busy_after_39_ticks", busy, 1);
    expect_timeout();
    ticks(1);
    cyc();
    cyc();

    // Press coincident with the 40th tick wins: btn[2] -> code 1 == action 1.
    start_round(2'd1);
    ticks(39);
    expect_press(2'd1, 2'd1, 1'b0);
    tick = 1'b1;
    press(4'b0100, 1'b0);
    tick = 1'b0;

    // btn[2] held across round_start is ignored; a round_start in WAIT is ignored too.
    btn = 4'b0100;
    cyc();
    start_round(2'd0);
    start_round(2'd1);
    cyc();
    check("held_button_not_judged", busy, 1);
    btn = '0;
    cyc();
    expect_press(2'd1, 2'd0, 1'b0);
    press(4'b0100, 1'b0);

    // Simultaneous new presses: btn[1] beats btn[3].
    start_round(2'd2);
    expect_press(2'd2, 2'd2, 1'b0);
    press(4'b1010, 1'b0);

    // Press in IDLE does not change operation.
    btn = 4'b0001;
    cyc();
    cyc();
    check("idle_press_operation_held", operation, 2);
    btn = '0;
    cyc();

    // Saturation of right_time.
    for (int r = 0; r < 300; r++) begin
      start_round(2'd3);
      expect_press(2'd3, 2'd3, 1'b0);
      press(4'b0001, 1'b0);
    end
    check("right_saturated", right_time, 255);

    // score_clr coincident with a hit wins.
    start_round(2'd3);
    expect_press(2'd3, 2'd3, 1'b1);
    press(4'b0001, 1'b1);

    // Reset mid-window: abandon round, outputs back to reset values.
    start_round(2'd1);
    ticks(10);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_right = 0;
    exp_wrong = 0;
    exp_op    = 2'd0;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("midreset_still_idle", busy, 0);

    // Normal round after reset.
    start_round(2'd1);
    expect_press(2'd1, 2'd1, 1'b0);
    press(4'b0100, 1'b0);

    repeat (3) cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_judge.md
# reaction_judge

Parametrised per-round answer judge for the reflex game. The level sequencer issues a prompt (expected action code) with `round_start`. The block then waits up to a configurable number of timebase ticks for a fresh button press. It classifies the round as hit, wrong press or timeout, keeps saturating right/wrong tallies, and reports the player's operation. It sits between the debounced button front end and the score/display logic.

## Interface
- `NUM_BTN`, 4: number of answer buttons (2..16).
- `ACT_W`, 2: action/operation code width; must satisfy 2^ACT_W >= NUM_BTN.
- `WINDOW_TICKS`, 40: answer window length in `tick` strobes (1..255).
- `CNT_W`, 8: width of the right/wrong tallies.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle timebase strobe (e.g. 100 ms).
- `round_start` in 1: one-cycle pulse; latch `action` and open the window.
- `action` in ACT_W: expected code for this round.
- `btn` in NUM_BTN: debounced, clk-synchronous button levels.
- `score_clr` in 1: synchronous clear of both tallies.
- `busy` out 1: high while a window is open (state WAIT).
- `operation` out ACT_W: code of the last judged press; holds its value between presses.
- `op_valid` out 1: one-cycle pulse when `operation` updates.
- `round_done` out 1: one-cycle pulse when a round resolves.
- `round_hit` out 1: result of the last round (1 = correct press); holds until the next `round_start`.
- `right_time` out CNT_W: count of correct rounds, saturating.
- `wrong_time` out CNT_W: count of wrong presses plus timeouts, saturating.

## Operation
- **Button encoding:** `btn[i]` maps to code `NUM_BTN-1-i`. With `NUM_BTN=4`, btn[0]→3 and btn[3]→0.
- **Edge detection:** `new_press = btn & ~btn_q`. `btn_q` is a register updated every cycle in every state. A button held from before `round_start` therefore never counts.
- **Priority:** when several new presses occur in one cycle, the lowest `btn` index wins.
- **States:**
  - IDLE: `busy=0`. On `round_start`, latch `action` into `act_q`, clear `tick_cnt`, clear `round_hit`, and go to WAIT.
  - WAIT: evaluated each cycle, in this order:
    1. If `new_press` is nonzero: set `operation` to the winning code, pulse `op_valid`, and go to DONE. If code == `act_q`: `right_time`+1 and `round_hit`=1. Otherwise `wrong_time`+1 and `round_hit`=0.
    2. Else if `tick`: if `tick_cnt == WINDOW_TICKS-1`, `wrong_time`+1, `round_hit`=0, and go to DONE. Otherwise `tick_cnt`+1.
  - DONE: `round_done=1` for exactly this cycle, then go to IDLE.
- `round_start` received in WAIT or DONE is ignored; there is no restart mid-window.
- Presses in IDLE or DONE are not judged and do not change `operation`.
- **Tallies:** saturate at 2^CNT_W−1 and never wrap.
- **`score_clr`:** zeroes both tallies in any state. If it coincides with an increment, the clear wins. FSM and `round_hit` are unaffected.
- **`tick_cnt` width:** 8 bits, unsigned. `WINDOW_TICKS` above 255 is illegal.

## Timing
- **Reset values:** state IDLE, `btn_q=0`, `tick_cnt=0`, `act_q=0`, `operation=0`, `op_valid=0`, `round_done=0`, `round_hit=0`, `busy=0`, `right_time=0`, `wrong_time=0`.
- **Press latency:** a press seen as an edge in cycle k updates `operation`, `op_valid` and the tally at the clock edge ending cycle k. `round_done` is high in cycle k+1.
- **Timeout latency:** the WINDOW_TICKS-th tick observed in WAIT resolves the round in that cycle. A `tick` coincident with `round_start` is not counted.
- **Press vs. final tick in the same cycle:** the press wins, and the round is judged on the press.
- **Minimum round spacing:** the earliest accepted next `round_start` is in the cycle after DONE (IDLE).
- **Reset mid-window:** the round is abandoned, all outputs return to reset values, and no tally change or `round_done` is produced.

## Structure
- Shared package `judge_pkg`:
  - state encoding (IDLE/WAIT/DONE);
  - function mapping button index to code (`NUM_BTN-1-i`);
  - saturating-increment function.
- One sub-module, `btn_edge_pri`, parametrised by `NUM_BTN` and `ACT_W`. It contains the `btn_q` register, rising-edge detection and the lowest-index priority encoder. Outputs are `press` (1 bit) and `code`.
- The FSM, tick counter and tallies live in `reaction_judge`.

## Test plan
1. **Correct press:** `action=3`, `round_start`; 5 ticks later `btn=0001` → `operation=3`, `op_valid` pulse, `right_time` 0→1, `round_hit=1`, `round_done` one cycle later.
2. **Wrong press:** `action=0`, press `btn[1]` → `operation=2`, `wrong_time`+1, `round_hit=0`.
3. **Timeout:** `action=1`, no press, 40 ticks → `wrong_time`+1 on the 40th tick, no `op_valid`. A press on the same cycle as the 40th tick is instead judged as a press.
4. **Held button and simultaneous presses:** `btn[2]` held across `round_start` → not judged until released and re-pressed. New presses `btn=1010` in one cycle → `operation=2` (btn[1] wins).
5. **Saturation and clear:** 300 correct rounds with `CNT_W=8` → `right_time` stays at 255. Then `score_clr` coincident with a hit → both tallies read 0.
6. **Reset mid-window:** assert `rst` 10 ticks into WAIT → `busy=0`, all outputs at reset values, no `round_done`. The next `round_start` behaves normally.
